input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive clocks a synchronized input must differ from its debounced value before the debounced value updates; legal range 1 to 2^24-1.
REQ-002 Parameter SW_WIDTH, default 10, number of slide-switch channels.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port sw_raw  input  SW_WIDTH  asynchronous raw slide-switch levels.
REQ-006 Port btn_raw  input  1  asynchronous raw push-button level, 1 = pressed.
REQ-007 Port sw  output  SW_WIDTH  debounced switch levels, feeds downstream LED controller sw input.
REQ-008 Port btn  output  1  debounced button level, feeds downstream LED controller btn input.
REQ-009 Port btn_rise  output  1  one-cycle pulse on debounced button press.
REQ-010 Port btn_fall  output  1  one-cycle pulse on debounced button release.
REQ-011 Port sw_changed  output  1  one-cycle pulse when any debounced switch bit changes.

Function
REQ-012 Each of the SW_WIDTH+1 channels SHALL pass through a two-stage flip-flop synchronizer before any other logic; no raw input drives other logic directly.
REQ-013 Each channel SHALL own an independent counter of width ceil(log2(DEBOUNCE_CYCLES))+1 bits; counters never wrap.
REQ-014 On an edge where synchronized value equals debounced value, that channel's counter SHALL clear to 0.
REQ-015 On an edge where they differ and counter < DEBOUNCE_CYCLES-1, counter SHALL increment by 1 and debounced value holds.
REQ-016 On an edge where they differ and counter == DEBOUNCE_CYCLES-1, debounced value SHALL take the synchronized value and counter SHALL clear to 0.
REQ-017 Latency: a raw level held constant SHALL appear on sw/btn at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw level as edge 1.
REQ-018 A raw pulse or bounce with fewer than DEBOUNCE_CYCLES consecutive differing synchronized samples SHALL leave the debounced output unchanged.
REQ-019 btn_rise SHALL be high for exactly the one cycle in which btn first reads 1 after being 0; btn_fall likewise for 1->0; never both high together.
REQ-020 sw_changed SHALL be high for exactly the first cycle in which sw holds a new value; simultaneous changes on several bits SHALL produce a single one-cycle pulse.
REQ-021 Channels SHALL be fully independent: activity on one channel does not alter another channel's counter or timing.
REQ-022 Debounced outputs and pulses SHALL be registered outputs, glitch-free, no combinational path from any raw input.

Reset
REQ-023 While rst is high at a rising edge, all synchronizer stages, counters, sw, btn, btn_rise, btn_fall and sw_changed SHALL be 0 after that edge.
REQ-024 rst asserted mid-debounce SHALL discard partial counts; after release, a held raw level needs the full REQ-017 latency again.
REQ-025 If raw inputs are high when rst deasserts, outputs SHALL reach 1 via the normal debounce path (REQ-017) and SHALL generate the corresponding btn_rise / sw_changed pulse.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=10)
REQ-026 Reset then sw_raw=10'b1111111111 held -> sw stays 0 for 5 edges, sw=10'h3FF at edge 6, sw_changed high that cycle only.
REQ-027 btn_raw high 3 clocks then low, repeated -> btn stays 0, btn_rise never asserted.
REQ-028 btn_raw held high 20 clocks then low 20 clocks -> btn 1 at edge 6 with one btn_rise pulse; btn 0 six edges after release with one btn_fall pulse.
REQ-029 sw_raw 0 -> 10'b1010101010 in one cycle -> sw=10'b1010101010 at edge 6, exactly one sw_changed pulse.
REQ-030 btn_raw high, rst asserted at edge 3 for one cycle, btn_raw stays high -> btn remains 0 until 6 edges after rst release, then btn=1 with btn_rise.
REQ-031 sw_raw[0] bounces every cycle while sw_raw[9] held high -> sw[9]=1 at edge 6, sw[0] stays 0.

Source files
------------

// File: rtl/input_conditioner.sv
// Input conditioner for slide switches and one push button.
// Every channel is synchronized through two flops, then debounced by its own
// saturating counter. Button press/release and any-switch-change events are
// emitted as registered single-cycle pulses.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic                btn_raw,
    output logic [SW_WIDTH-1:0] sw,
    output logic                btn,
    output logic                btn_rise,
    output logic                btn_fall,
    output logic                sw_changed
);

    // Button is the top channel, switches occupy the low bits
    localparam int            CH   = SW_WIDTH + 1;
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CH-1:0] raw_all;
    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;
    logic [CH-1:0] deb;
    logic [CH-1:0] differ;
    logic [CH-1:0] update;
    logic [CW-1:0] cnt [CH];

    assign raw_all = {btn_raw, sw_raw};

    // Two-stage synchronizer; nothing downstream ever looks at raw_all
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
        end
    end

    // A channel commits when it has disagreed for the full debounce window
    always_comb begin
        differ = '0;
        update = '0;
        for (int i = 0; i < CH; i++) begin
            differ[i] = sync2[i] ^ deb[i];
            update[i] = differ[i] && (cnt[i] == LAST);
        end
    end

    // Per-channel counters: clear on agreement, count while disagreeing, commit at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!differ[i]) begin
                    cnt[i] <= '0;
                end else if (update[i]) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Event pulses are registered alongside the commit so they line up with the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            btn_rise   <= update[SW_WIDTH] & sync2[SW_WIDTH];
            btn_fall   <= update[SW_WIDTH] & ~sync2[SW_WIDTH];
            sw_changed <= |update[SW_WIDTH-1:0];
        end
    end

    assign sw  = deb[SW_WIDTH-1:0];
    assign btn = deb[SW_WIDTH];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

    localparam int N  = 4;
    localparam int SW = 10;

    logic          clk;
    logic          rst;
    logic [SW-1:0] sw_raw;
    logic          btn_raw;
    logic [SW-1:0] sw;
    logic          btn;
    logic          btn_rise;
    logic          btn_fall;
    logic          sw_changed;

    int checks = 0;
    int passes = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .SW_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .sw(sw),
        .btn(btn),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .sw_changed(sw_changed)
    );

    // Free-running 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        sw_raw  = 10'h3FF;
        btn_raw = 1'b1;
        tick();
        tick();
        checks++;
        if ({sw, btn, btn_rise, btn_fall, sw_changed} !== 14'h0) begin
            $display("[TB] FAIL reset_outputs got=%h want=%h", {sw, btn, btn_rise, btn_fall, sw_changed}, 14'h0);
        end else passes++;
        sw_raw  = '0;
        btn_raw = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({sw, btn} !== 11'h0) begin
            $display("[TB] FAIL idle_after_reset got=%h want=%h", {sw, btn}, 11'h0);
        end else passes++;
    endtask

    task automatic test_switch_all;
        logic [SW-1:0] exp_sw;
        logic          exp_ch;
        sw_raw = 10'h3FF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_sw = (e >= 6) ? 10'h3FF : 10'h000;
            exp_ch = (e == 6);
            checks++;
            if (sw !== exp_sw || sw_changed !== exp_ch) begin
                $display("[TB] FAIL sw_all_edge%0d got sw=%h ch=%b want sw=%h ch=%b", e, sw, sw_changed, exp_sw, exp_ch);
            end else passes++;
        end
        sw_raw = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_sw = (e >= 6) ? 10'h000 : 10'h3FF;
            exp_ch = (e == 6);
            checks++;
            if (sw !== exp_sw || sw_changed !== exp_ch) begin
                $display("[TB] FAIL sw_all_off_edge%0d got sw=%h ch=%b want sw=%h ch=%b", e, sw, sw_changed, exp_sw, exp_ch);
            end else passes++;
        end
    endtask

    task automatic test_btn_bounce;
        int bad = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++) begin
                btn_raw = (k < 3);
                tick();
                if (btn !== 1'b0 || btn_rise !== 1'b0) bad++;
            end
        end
        btn_raw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (btn !== 1'b0 || btn_rise !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("[TB] FAIL btn_bounce got bad_cycles=%0d want 0", bad);
        end else passes++;
    endtask

    task automatic test_btn_press;
        int rises = 0;
        int falls = 0;
        int both  = 0;
        logic exp_b;
        btn_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_b = (e >= 6);
            if (btn_rise) rises++;
            if (btn_fall) falls++;
            if (btn_rise && btn_fall) both++;
            checks++;
            if (btn !== exp_b || btn_rise !== (e == 6)) begin
                $display("[TB] FAIL btn_press_edge%0d got btn=%b rise=%b want btn=%b rise=%b", e, btn, btn_rise, exp_b, (e == 6));
            end else passes++;
        end
        btn_raw = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_b = (e < 6);
            if (btn_rise) rises++;
            if (btn_fall) falls++;
            if (btn_rise && btn_fall) both++;
            checks++;
            if (btn !== exp_b || btn_fall !== (e == 6)) begin
                $display("[TB] FAIL btn_release_edge%0d got btn=%b fall=%b want btn=%b fall=%b", e, btn, btn_fall, exp_b, (e == 6));
            end else passes++;
        end
        checks++;
        if (rises != 1 || falls != 1 || both != 0) begin
            $display("[TB] FAIL btn_pulse_counts got rise=%0d fall=%0d both=%0d want 1 1 0", rises, falls, both);
        end else passes++;
    endtask

    task automatic test_boundary;
        // Exactly DEBOUNCE_CYCLES samples high is just enough to commit
        logic exp_b;
        btn_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) btn_raw = 1'b0;
            tick();
            exp_b = (e >= 6 && e < 10);
            checks++;
            if (btn !== exp_b || btn_rise !== (e == 6) || btn_fall !== (e == 10)) begin
                $display("[TB] FAIL boundary_edge%0d got btn=%b rise=%b fall=%b want btn=%b rise=%b fall=%b",
                         e, btn, btn_rise, btn_fall, exp_b, (e == 6), (e == 10));
            end else passes++;
        end
    endtask

    task automatic test_sw_pattern;
        int pulses = 0;
        logic [SW-1:0] exp_sw;
        sw_raw = 10'b1010101010;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (sw_changed) pulses++;
            exp_sw = (e >= 6) ? 10'b1010101010 : 10'h000;
            checks++;
            if (sw !== exp_sw) begin
                $display("[TB] FAIL sw_pattern_edge%0d got=%h want=%h", e, sw, exp_sw);
            end else passes++;
        end
        checks++;
        if (pulses != 1) begin
            $display("[TB] FAIL sw_pattern_pulses got=%0d want=1", pulses);
        end else passes++;
    endtask

    task automatic test_reset_mid;
        // sw_raw is still 2AA here, so the switches re-debounce after reset too
        btn_raw = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({sw, btn, btn_rise, btn_fall, sw_changed} !== 14'h0) begin
            $display("[TB] FAIL reset_mid_clear got=%h want=%h", {sw, btn, btn_rise, btn_fall, sw_changed}, 14'h0);
        end else passes++;
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (btn !== (e >= 6) || btn_rise !== (e == 6) ||
                sw !== ((e >= 6) ? 10'h2AA : 10'h000) || sw_changed !== (e == 6)) begin
                $display("[TB] FAIL reset_mid_edge%0d got btn=%b rise=%b sw=%h ch=%b want btn=%b rise=%b",
                         e, btn, btn_rise, sw, sw_changed, (e >= 6), (e == 6));
            end else passes++;
        end
    endtask

    task automatic test_independence;
        logic [SW-1:0] exp_sw;
        int bad0 = 0;
        sw_raw  = '0;
        btn_raw = 1'b0;
        rst     = 1'b1;
        tick();
        rst    = 1'b0;
        sw_raw = 10'h201;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (sw[0] !== 1'b0) bad0++;
            exp_sw = (e >= 6) ? 10'h200 : 10'h000;
            checks++;
            if (sw !== exp_sw || sw_changed !== (e == 6)) begin
                $display("[TB] FAIL indep_edge%0d got sw=%h ch=%b want sw=%h ch=%b", e, sw, sw_changed, exp_sw, (e == 6));
            end else passes++;
            sw_raw[0] = ~sw_raw[0];
        end
        checks++;
        if (bad0 != 0) begin
            $display("[TB] FAIL indep_bit0 got high_cycles=%0d want 0", bad0);
        end else passes++;
    endtask

    // Scenario sequence
    initial begin
        rst     = 1'b1;
        sw_raw  = '0;
        btn_raw = 1'b0;
        test_reset();
        test_switch_all();
        test_btn_bounce();
        test_btn_press();
        test_boundary();
        for (int i = 0; i < 8; i++) tick();
        test_sw_pattern();
        test_reset_mid();
        test_independence();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
